// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared pipeline definitions for the memory stage and its helpers.
//   state_e            : memory-stage FSM encoding (idle / waiting on memory)
//   FLAG_N/Z/C/V       : bit positions of the NZCV flags in a 4-bit flag word
//   FLAG_W             : width of a flag word / branch condition mask
//   is_word_aligned()  : true when a byte address sits on a 32-bit boundary
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int FLAG_W = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
// Combinational branch decision: a branch is taken when any flag selected
// by the condition mask is set in the current instruction's NZCV flags.
//   branch   in  FLAG_W  condition mask, one bit per flag
//   alu_cond in  FLAG_W  NZCV flags of the instruction
//   taken    out 1       branch should redirect fetch
// ---------------------------------------------------------------------------
module branch_resolve
  import mem_stage_pkg::*;
(
  input  logic [FLAG_W-1:0] branch,
  input  logic [FLAG_W-1:0] alu_cond,
  output logic              taken
);

  assign taken = (branch[FLAG_N] & alu_cond[FLAG_N]) |
                 (branch[FLAG_Z] & alu_cond[FLAG_Z]) |
                 (branch[FLAG_C] & alu_cond[FLAG_C]) |
                 (branch[FLAG_V] & alu_cond[FLAG_V]);

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory stage of the pipeline. Retires ALU instructions in one cycle,
// issues word-aligned loads/stores to data memory and stalls execution
// until the memory acknowledges, flags misaligned accesses, resolves
// branches and hands results to the writeback latch.
//   clk, rst_n                     clock, synchronous active-low reset
//   ex_valid, alu_result, st_data  execution latch contents
//   new_pc, rd_in, branch, alu_cond
//   mem_rd, mem_wr, reg_wr         load / store / register-write controls
//   stall_ex                       hold the execution latch (combinational)
//   dm_req, dm_we, dm_addr,        data-memory request interface
//   dm_wdata, dm_rdata, dm_ack
//   br_taken, br_target            one-cycle fetch redirect
//   cond_out                       flags of the last accepted instruction
//   wb_valid, wb_we, wb_rd,        writeback latch
//   wb_data
//   misalign                       one-cycle pulse on a misaligned access
// ---------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] new_pc,
  input  logic [RD_W-1:0]   rd_in,
  input  logic [FLAG_W-1:0] branch,
  input  logic [FLAG_W-1:0] alu_cond,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              reg_wr,
  output logic              stall_ex,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic [FLAG_W-1:0] cond_out,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign
);

  state_e            state, next_state;
  logic              accept;
  logic              is_mem;
  logic              aligned;
  logic              ack_seen;
  logic              take_branch;
  logic [RD_W-1:0]   pend_rd;
  logic              pend_reg_wr;

  // Instructions are only taken while idle; anything presented during WAIT
  // is held upstream by stall_ex and must not disturb the stage. A store
  // wins whenever mem_wr is set, so mem_rd only matters on its own.
  assign accept   = (state == ST_IDLE) && ex_valid;
  assign is_mem   = mem_rd | mem_wr;
  assign aligned  = is_word_aligned(alu_result[1:0]);
  assign ack_seen = (state == ST_WAIT) && dm_req && dm_ack;

  branch_resolve u_branch_resolve (
    .branch   (branch),
    .alu_cond (alu_cond),
    .taken    (take_branch)
  );

  // State register for the two-state memory FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: an aligned memory access parks the stage in WAIT
  // until the memory acknowledges; stall_ex simply mirrors WAIT.
  always_comb begin
    next_state = state;
    stall_ex   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && is_mem && aligned) begin
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_ex = 1'b1;
        if (ack_seen) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath registers. Pulses (wb_valid, wb_we, misalign, br_taken) fall
  // back to zero every cycle unless this edge produces one. The memory
  // request fields are only loaded on acceptance, which keeps them stable
  // for the whole time dm_req is high. rd and reg_wr of an outstanding
  // access are parked in pend_* until the ack arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      br_taken    <= 1'b0;
      br_target   <= '0;
      cond_out    <= '0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      misalign    <= 1'b0;
      pend_rd     <= '0;
      pend_reg_wr <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      misalign <= 1'b0;
      br_taken <= 1'b0;
      if (accept) begin
        cond_out  <= alu_cond;
        br_taken  <= take_branch;
        br_target <= new_pc;
        if (!is_mem) begin
          wb_valid <= 1'b1;
          wb_we    <= reg_wr;
          wb_rd    <= rd_in;
          wb_data  <= alu_result;
        end else if (!aligned) begin
          misalign <= 1'b1;
          wb_valid <= 1'b1;
          wb_rd    <= rd_in;
        end else begin
          dm_req      <= 1'b1;
          dm_we       <= mem_wr;
          dm_addr     <= alu_result;
          dm_wdata    <= st_data;
          pend_rd     <= rd_in;
          pend_reg_wr <= reg_wr;
        end
      end else if (ack_seen) begin
        dm_req   <= 1'b0;
        dm_we    <= 1'b0;
        wb_valid <= 1'b1;
        wb_rd    <= pend_rd;
        if (!dm_we) begin
          wb_we   <= pend_reg_wr;
          wb_data <= dm_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Scoreboard bench for mem_stage. The driver issues directed and random
// instructions, plays the data memory, and records what each clock edge
// should produce; a separate monitor compares DUT outputs as they appear.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [31:0] new_pc;
    logic [31:0] rdata;
    logic [5:0]  rd;
    logic [3:0]  branch;
    logic [3:0]  cond;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    int          delay;
  } instr_t;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [3:0]  cond;
    logic        mis;
  } cyc_t;

  typedef struct {
    logic [5:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        full;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] alu_result;
  logic [31:0] st_data;
  logic [31:0] new_pc;
  logic [5:0]  rd_in;
  logic [3:0]  branch;
  logic [3:0]  alu_cond;
  logic        mem_rd;
  logic        mem_wr;
  logic        reg_wr;
  logic        stall_ex;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        br_taken;
  logic [31:0] br_target;
  logic [3:0]  cond_out;
  logic        wb_valid;
  logic        wb_we;
  logic [5:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  cyc_t cq[$];
  wb_t  wq[$];
  logic [3:0] exp_cond = 4'h0;
  int checks = 0;
  int errors = 0;

  mem_stage #(.DATA_W(32), .RD_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .alu_result (alu_result),
    .st_data    (st_data),
    .new_pc     (new_pc),
    .rd_in      (rd_in),
    .branch     (branch),
    .alu_cond   (alu_cond),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .reg_wr     (reg_wr),
    .stall_ex   (stall_ex),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_ack     (dm_ack),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .cond_out   (cond_out),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  // A branch is taken if any flag it asks for is present.
  function automatic logic ref_taken(input logic [3:0] br, input logic [3:0] c);
    logic t;
    t = 1'b0;
    for (int f = 0; f < 4; f++) begin
      if (br[f] && c[f]) t = 1'b1;
    end
    return t;
  endfunction

  function automatic instr_t mk(input logic [31:0] addr, input logic [31:0] sd,
                                input logic [31:0] pc, input logic [5:0] rd,
                                input logic [3:0] br, input logic [3:0] c,
                                input logic mrd, input logic mwr, input logic rwr,
                                input int dly, input logic [31:0] rdata);
    instr_t i;
    i.addr = addr; i.st_data = sd; i.new_pc = pc; i.rd = rd;
    i.branch = br; i.cond = c; i.mem_rd = mrd; i.mem_wr = mwr;
    i.reg_wr = rwr; i.delay = dly; i.rdata = rdata;
    return i;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Random upstream contents; the DUT must ignore them unless it accepts.
  task automatic drive_junk(input logic v);
    rst_n      = 1'b1;
    ex_valid   = v;
    alu_result = $urandom;
    st_data    = $urandom;
    new_pc     = $urandom;
    rd_in      = 6'($urandom);
    branch     = 4'($urandom);
    alu_cond   = 4'($urandom);
    mem_rd     = 1'($urandom);
    mem_wr     = 1'($urandom);
    reg_wr     = 1'($urandom);
  endtask

  task automatic push_quiet(input logic stall);
    cyc_t e;
    e = '{stall: stall, br: 1'b0, tgt: 32'h0, cond: exp_cond, mis: 1'b0};
    cq.push_back(e);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive_junk(1'b0);
    dm_ack = 1'b0;
    push_quiet(1'b0);
    @(posedge clk);
  endtask

  task automatic applyStimulus(input instr_t ins);
    cyc_t e;
    wb_t  w;
    logic memop, mis, go_wait;
    @(negedge clk);
    rst_n = 1'b1;
    ex_valid = 1'b1; alu_result = ins.addr; st_data = ins.st_data;
    new_pc = ins.new_pc; rd_in = ins.rd; branch = ins.branch;
    alu_cond = ins.cond; mem_rd = ins.mem_rd; mem_wr = ins.mem_wr;
    reg_wr = ins.reg_wr; dm_ack = 1'b0;
    memop   = ins.mem_rd | ins.mem_wr;
    mis     = memop && (ins.addr[1:0] != 2'b00);
    go_wait = memop && !mis;
    exp_cond = ins.cond;
    e = '{stall: go_wait, br: ref_taken(ins.branch, ins.cond), tgt: ins.new_pc,
          cond: ins.cond, mis: mis};
    cq.push_back(e);
    if (!memop) begin
      w = '{rd: ins.rd, we: ins.reg_wr, data: ins.addr, full: 1'b1};
      wq.push_back(w);
    end else if (mis) begin
      w = '{rd: ins.rd, we: 1'b0, data: 32'h0, full: 1'b0};
      wq.push_back(w);
    end
    @(posedge clk);
    #1;
    if (go_wait) begin
      checkOutput("dm_req_issue", 32'(dm_req), 32'd1);
      checkOutput("dm_we", 32'(dm_we), 32'(ins.mem_wr));
      checkOutput("dm_addr", dm_addr, ins.addr);
      if (ins.mem_wr) checkOutput("dm_wdata", dm_wdata, ins.st_data);
      for (int i = 0; i < ins.delay; i++) begin
        @(negedge clk);
        drive_junk(1'($urandom));
        dm_ack = 1'b0;
        push_quiet(1'b1);
        @(posedge clk);
        #1;
        checkOutput("dm_req_hold", 32'(dm_req), 32'd1);
        checkOutput("dm_addr_hold", dm_addr, ins.addr);
      end
      @(negedge clk);
      drive_junk(1'($urandom));
      dm_ack   = 1'b1;
      dm_rdata = ins.rdata;
      if (ins.mem_wr) w = '{rd: ins.rd, we: 1'b0, data: 32'h0, full: 1'b0};
      else            w = '{rd: ins.rd, we: ins.reg_wr, data: ins.rdata, full: 1'b1};
      wq.push_back(w);
      push_quiet(1'b0);
      @(posedge clk);
      #1;
      checkOutput("dm_req_drop", 32'(dm_req), 32'd0);
    end else if (memop) begin
      checkOutput("dm_req_misalign", 32'(dm_req), 32'd0);
    end
  endtask

  // A load is abandoned by reset while waiting; the late ack must do nothing.
  task automatic reset_mid_wait();
    cyc_t e;
    @(negedge clk);
    drive_junk(1'b1);
    alu_result = 32'h100; mem_rd = 1'b1; mem_wr = 1'b0; reg_wr = 1'b1;
    branch = 4'h0; alu_cond = 4'h3; rd_in = 6'd7; dm_ack = 1'b0;
    exp_cond = 4'h3;
    e = '{stall: 1'b1, br: 1'b0, tgt: 32'h0, cond: 4'h3, mis: 1'b0};
    cq.push_back(e);
    @(posedge clk);
    #1;
    checkOutput("rst_wait_req", 32'(dm_req), 32'd1);
    @(negedge clk);
    drive_junk(1'b0);
    rst_n = 1'b0;
    exp_cond = 4'h0;
    push_quiet(1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_wait_req_cleared", 32'(dm_req), 32'd0);
    checkOutput("rst_wait_addr_cleared", dm_addr, 32'h0);
    checkOutput("rst_wait_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    drive_junk(1'b0);
    dm_ack = 1'b1;
    dm_rdata = 32'h0BADF00D;
    push_quiet(1'b0);
    @(posedge clk);
    #1;
    checkOutput("late_ack_req", 32'(dm_req), 32'd0);
    checkOutput("late_ack_wb_valid", 32'(wb_valid), 32'd0);
  endtask

  // Monitor: compares per-cycle outputs against the driver's expectations
  // and every writeback pulse against the scoreboard queue.
  initial begin
    cyc_t e;
    wb_t  w;
    forever begin
      @(posedge clk);
      #1;
      if (cq.size() > 0) begin
        e = cq.pop_front();
        checkOutput("stall_ex", 32'(stall_ex), 32'(e.stall));
        checkOutput("br_taken", 32'(br_taken), 32'(e.br));
        if (e.br) checkOutput("br_target", br_target, e.tgt);
        checkOutput("cond_out", 32'(cond_out), 32'(e.cond));
        checkOutput("misalign", 32'(misalign), 32'(e.mis));
      end
      if (wb_valid === 1'b1) begin
        if (wq.size() == 0) begin
          checkOutput("wb_spurious", 32'(wb_valid), 32'd0);
        end else begin
          w = wq.pop_front();
          checkOutput("wb_we", 32'(wb_we), 32'(w.we));
          if (w.full) begin
            checkOutput("wb_rd", 32'(wb_rd), 32'(w.rd));
            checkOutput("wb_data", wb_data, w.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the run completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    instr_t ins;
    int kind;
    logic [31:0] r;
    rst_n = 1'b0; ex_valid = 1'b0; alu_result = '0; st_data = '0; new_pc = '0;
    rd_in = '0; branch = '0; alu_cond = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    reg_wr = 1'b0; dm_rdata = '0; dm_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      push_quiet(1'b0);
      @(posedge clk);
    end
    #1;
    checkOutput("reset_dm_req", 32'(dm_req), 32'd0);
    checkOutput("reset_dm_we", 32'(dm_we), 32'd0);
    checkOutput("reset_dm_addr", dm_addr, 32'h0);
    checkOutput("reset_dm_wdata", dm_wdata, 32'h0);
    checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset_wb_we", 32'(wb_we), 32'd0);
    checkOutput("reset_wb_data", wb_data, 32'h0);
    checkOutput("reset_wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("reset_br_target", br_target, 32'h0);

    applyStimulus(mk(32'h10, 32'h0, 32'h0, 6'd5, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 0, 32'h0));
    applyStimulus(mk(32'h100, 32'h0, 32'h0, 6'd3, 4'h0, 4'h1, 1'b1, 1'b0, 1'b1, 3, 32'hDEADBEEF));
    applyStimulus(mk(32'h20, 32'hCAFE, 32'h0, 6'd9, 4'h0, 4'h2, 1'b1, 1'b1, 1'b1, 1, 32'h12345678));
    applyStimulus(mk(32'h102, 32'h0, 32'h0, 6'd4, 4'h0, 4'h8, 1'b1, 1'b0, 1'b1, 0, 32'h0));
    applyStimulus(mk(32'h0, 32'h0, 32'h40, 6'd1, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 0, 32'h0));
    applyStimulus(mk(32'h0, 32'h0, 32'h80, 6'd1, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 32'h0));
    idle_cycle();
    reset_mid_wait();
    idle_cycle();
    idle_cycle();

    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 3);
      ins.addr = $urandom; ins.st_data = $urandom; ins.new_pc = $urandom;
      ins.rdata = $urandom; ins.rd = 6'($urandom); ins.branch = 4'($urandom);
      ins.cond = 4'($urandom); ins.reg_wr = 1'($urandom);
      ins.delay = $urandom_range(0, 3);
      case (kind)
        0: begin ins.mem_rd = 1'b0; ins.mem_wr = 1'b0; end
        1: begin ins.mem_rd = 1'b1; ins.mem_wr = 1'b0; ins.addr[1:0] = 2'b00; end
        2: begin ins.mem_rd = 1'($urandom); ins.mem_wr = 1'b1; ins.addr[1:0] = 2'b00; end
        default: begin
          r = $urandom;
          ins.mem_wr = r[0];
          ins.mem_rd = ~r[0];
          ins.addr[1:0] = 2'($urandom_range(1, 3));
        end
      endcase
      applyStimulus(ins);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    for (int i = 0; i < 3; i++) idle_cycle();
    #2;
    checkOutput("wb_missing", 32'(wq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath and address width.
REQ-002 Parameter RD_W, default 6, destination-register index width.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ex_valid  in  1  execution latch holds a valid instruction.
REQ-006 alu_result  in  DATA_W  ALU result, also the memory byte address.
REQ-007 st_data  in  DATA_W  store data (operand B).
REQ-008 new_pc  in  DATA_W  branch target.
REQ-009 rd_in  in  RD_W  destination register.
REQ-010 branch  in  4  branch condition mask.
REQ-011 alu_cond  in  4  NZCV flags of the current instruction.
REQ-012 mem_rd, mem_wr, reg_wr  in  1 each  load, store and register-write controls.
REQ-013 stall_ex  out  1  hold the execution latch.
REQ-014 dm_req, dm_we  out  1 each  data-memory request and write enable.
REQ-015 dm_addr, dm_wdata  out  DATA_W  memory address and write data.
REQ-016 dm_rdata  in  DATA_W; dm_ack  in  1  read data and access completion.
REQ-017 br_taken  out  1; br_target  out  DATA_W  redirect to fetch.
REQ-018 cond_out  out  4  registered flags returned to the execution stage.
REQ-019 wb_valid, wb_we  out  1 each; wb_rd  out  RD_W; wb_data  out  DATA_W  writeback latch.
REQ-020 misalign  out  1  one-cycle pulse on a misaligned access.

Function
REQ-021 FSM has two states, IDLE and WAIT; IDLE is entered on reset.
REQ-022 IDLE, ex_valid=1, no memory operation: the instruction retires next edge; wb_data=alu_result, wb_we=reg_wr, wb_valid=1.
REQ-023 IDLE, ex_valid=1, mem_rd or mem_wr with alu_result[1:0]=0: next edge latches address/data/rd, asserts dm_req, goes to WAIT.
REQ-024 When mem_rd and mem_wr are both 1, the access is a store and mem_rd is ignored.
REQ-025 dm_we=1 for stores; dm_addr, dm_wdata, dm_we stay stable while dm_req=1.
REQ-026 In WAIT, dm_ack is sampled only while dm_req=1; ack deasserts dm_req and returns to IDLE on the same edge.
REQ-027 Load completion: wb_data=dm_rdata, wb_we=reg_wr, wb_valid=1 on the ack edge.
REQ-028 Store completion: wb_valid=1, wb_we=0.
REQ-029 stall_ex = (state==WAIT), combinational; upstream inputs are ignored while in WAIT.
REQ-030 Misaligned access (alu_result[1:0]!=0): no dm_req, misalign=1 for one cycle, wb_valid=1, wb_we=0.
REQ-031 Branch: br_taken=1 for exactly one cycle after the accepting edge when ex_valid and |(branch & alu_cond); br_target=new_pc.
REQ-032 The branch decision is independent of memory operations.
REQ-033 cond_out is updated to alu_cond on every accepted instruction, otherwise held.
REQ-034 wb_valid is a one-cycle pulse per retired instruction; wb_valid=0 in cycles with nothing retiring.
REQ-035 Throughput: one instruction per cycle without memory operations; memory latency is 1 + ack-wait cycles.

Reset
REQ-036 On the edge with rst_n=0: state=IDLE; dm_req, dm_we, stall_ex, br_taken, wb_valid, wb_we and misalign are 0; all data and address outputs are 0; cond_out=0.
REQ-037 Reset during WAIT abandons the access: dm_req=0 next edge, no writeback; a later dm_ack is ignored.

Structure
REQ-038 FSM state encoding and flag-bit indices (N=3, Z=2, C=1, V=0) live in the shared pipeline package.
REQ-039 One sub-module, branch_resolve, computes the combinational taken signal from branch and alu_cond.

Verification
REQ-040 ALU op, alu_result=0x10, rd_in=5, reg_wr=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x10, stall_ex=0.
REQ-041 Load at 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> stall_ex high 4 cycles, then wb_data=0xDEADBEEF, wb_we=1.
REQ-042 Store 0xCAFE at 0x20 with mem_rd=1 also set -> dm_we=1, dm_wdata=0xCAFE, wb_we=0.
REQ-043 Load at 0x102 -> misalign pulse, dm_req never asserts, wb_we=0.
REQ-044 branch=4'b0100, alu_cond=4'b0100, new_pc=0x40 -> br_taken single pulse, br_target=0x40; with alu_cond=0 -> br_taken stays 0.
REQ-045 rst_n=0 mid-WAIT, then dm_ack=1 -> dm_req=0, no wb_valid, state IDLE.
